// File: rtl/motor_pwm_driver_if.sv
// motor_pwm_driver_if
//   Command/status bundle for the motor PWM driver.
//   master : drive-request side (enable, dir_cmd, duty_cmd, fault in; status out)
//   slave  : the driver itself
//   enable    - drive request, level-sensitive
//   dir_cmd   - requested direction, bit0 = channel A, bit1 = channel B
//   duty_cmd  - target duty in clk counts per PWM period
//   fault     - overcurrent flag, asynchronous to the driver clock
//   pwm_a/b   - gate drives; dir_a/b - latched direction
//   fault_led - high in FAULT and LOCKOUT; state - encoded FSM state
interface motor_pwm_driver_if;
    logic        enable;
    logic [1:0]  dir_cmd;
    logic [15:0] duty_cmd;
    logic        fault;
    logic        pwm_a;
    logic        pwm_b;
    logic        dir_a;
    logic        dir_b;
    logic        fault_led;
    logic [2:0]  state;

    modport master (
        output enable, dir_cmd, duty_cmd, fault,
        input  pwm_a, pwm_b, dir_a, dir_b, fault_led, state
    );

    modport slave (
        input  enable, dir_cmd, duty_cmd, fault,
        output pwm_a, pwm_b, dir_a, dir_b, fault_led, state
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   Two-channel motor gate driver: free-running PWM period counter, soft-start
//   duty ramp, glitch-free duty updates at period boundaries, direction-change
//   blanking, overcurrent fault handling with timed retries and lockout.
// Ports
//   clk - system clock (posedge)
//   rst - asynchronous active-high reset
//   bus - motor_pwm_driver_if.slave (commands in, gate drives / status out)
module motor_pwm_driver #(
    parameter int PWM_PERIOD  = 1000,
    parameter int RAMP_STEP   = 100000,
    parameter int RETRY_WAIT  = 200000000,
    parameter int MAX_RETRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    motor_pwm_driver_if.slave bus
);
    localparam int PW = $clog2(PWM_PERIOD + 1);
    localparam int SW = (RAMP_STEP   < 2) ? 1 : $clog2(RAMP_STEP + 1);
    localparam int WW = (RETRY_WAIT  < 2) ? 1 : $clog2(RETRY_WAIT + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PWM_PERIOD - 1);
    localparam logic [SW-1:0] S_LAST = SW'(RAMP_STEP - 1);
    localparam logic [WW-1:0] W_LAST = WW'(RETRY_WAIT - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
    localparam logic [15:0]   D_MAX  = 16'(PWM_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP    = 3'd1,
        S_RUN     = 3'd2,
        S_FAULT   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_fault_s1, r_fault_s2;
    logic [PW-1:0] r_pcnt;
    logic [15:0]   r_duty, w_duty_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic [RW-1:0] r_retry, w_retry_nxt;
    logic [WW-1:0] r_wait, w_wait_nxt;
    logic [SW-1:0] r_step, w_step_nxt;
    logic          r_pend, w_pend_nxt;   // a ramp step is owed at the next boundary
    logic          r_hold, w_hold_nxt;   // direction-change blanking period active
    logic [PW-1:0] r_hcnt, w_hcnt_nxt;
    logic          r_pwm, w_pwm_nxt;

    logic          w_fault_s, w_bnd, w_active, w_dir_chg, w_step_wrap;
    logic [15:0]   w_target, w_duty_inc;

    // Only the second synchronizer stage is ever looked at by the control logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_s1 <= 1'b0;
            r_fault_s2 <= 1'b0;
        end else begin
            r_fault_s1 <= bus.fault;
            r_fault_s2 <= r_fault_s1;
        end
    end
    assign w_fault_s = r_fault_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_pcnt <= '0;
        else if (r_pcnt == P_LAST) r_pcnt <= '0;
        else                      r_pcnt <= r_pcnt + 1'b1;
    end

    assign w_target    = (bus.duty_cmd > D_MAX) ? D_MAX : bus.duty_cmd;
    assign w_bnd       = (r_pcnt == P_LAST);
    assign w_active    = (r_state == S_RAMP) || (r_state == S_RUN);
    assign w_dir_chg   = w_active && !r_hold && (bus.dir_cmd != r_dir);
    assign w_step_wrap = (r_step == S_LAST);
    assign w_duty_inc  = r_duty + 16'd1;

    // Priority inside RAMP/RUN: enable low, then fault, then direction change.
    // The pwm flop is only loaded from the compare when the drive stays active
    // this cycle, so fault entry and direction change blank it on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        w_retry_nxt = r_retry;
        w_wait_nxt  = r_wait;
        w_step_nxt  = r_step;
        w_pend_nxt  = r_pend;
        w_hold_nxt  = r_hold;
        w_hcnt_nxt  = r_hcnt;
        w_pwm_nxt   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
            w_duty_nxt  = '0;
            w_retry_nxt = '0;
            w_wait_nxt  = '0;
            w_step_nxt  = '0;
            w_pend_nxt  = 1'b0;
            w_hold_nxt  = 1'b0;
            w_hcnt_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_fault_s) begin
                        w_state_nxt = S_RAMP;
                        w_dir_nxt   = bus.dir_cmd;
                        w_duty_nxt  = '0;
                        w_step_nxt  = '0;
                        w_pend_nxt  = 1'b0;
                        w_hold_nxt  = 1'b0;
                    end
                end
                S_RAMP, S_RUN: begin
                    if (w_fault_s) begin
                        w_state_nxt = S_FAULT;
                        w_wait_nxt  = '0;
                        w_hold_nxt  = 1'b0;
                        w_hcnt_nxt  = '0;
                    end else if (w_dir_chg) begin
                        w_state_nxt = S_RAMP;
                        w_duty_nxt  = '0;
                        w_hold_nxt  = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else if (r_hold) begin
                        // One full period at zero duty, then relatch and ramp again.
                        if (r_hcnt == P_LAST) begin
                            w_hold_nxt = 1'b0;
                            w_hcnt_nxt = '0;
                            w_dir_nxt  = bus.dir_cmd;
                            w_step_nxt = '0;
                            w_pend_nxt = 1'b0;
                        end else begin
                            w_hcnt_nxt = r_hcnt + 1'b1;
                        end
                    end else begin
                        w_pwm_nxt = (16'(r_pcnt) < r_duty);
                        if (r_state == S_RAMP) begin
                            w_step_nxt = w_step_wrap ? '0 : r_step + 1'b1;
                            w_pend_nxt = r_pend | w_step_wrap;
                            if (w_bnd) begin
                                if (r_duty >= w_target) begin
                                    w_duty_nxt  = w_target;
                                    w_state_nxt = S_RUN;
                                end else if (r_pend) begin
                                    w_duty_nxt = w_duty_inc;
                                    w_pend_nxt = w_step_wrap;
                                    if (w_duty_inc == w_target) w_state_nxt = S_RUN;
                                end
                            end
                        end else if (w_bnd) begin
                            w_duty_nxt = w_target;
                        end
                    end
                end
                S_FAULT: begin
                    if (r_wait == W_LAST) begin
                        w_wait_nxt = '0;
                        if (r_retry >= R_MAX) begin
                            w_state_nxt = S_LOCKOUT;
                        end else if (!w_fault_s) begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_duty_nxt  = '0;
                            w_step_nxt  = '0;
                            w_pend_nxt  = 1'b0;
                            w_state_nxt = S_RAMP;
                        end
                    end else begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                end
                S_LOCKOUT: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_dir   <= '0;
            r_retry <= '0;
            r_wait  <= '0;
            r_step  <= '0;
            r_pend  <= 1'b0;
            r_hold  <= 1'b0;
            r_hcnt  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
            r_retry <= w_retry_nxt;
            r_wait  <= w_wait_nxt;
            r_step  <= w_step_nxt;
            r_pend  <= w_pend_nxt;
            r_hold  <= w_hold_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_pwm   <= w_pwm_nxt;
        end
    end

    assign bus.pwm_a     = r_pwm;
    assign bus.pwm_b     = r_pwm;
    assign bus.dir_a     = r_dir[0];
    assign bus.dir_b     = r_dir[1];
    assign bus.fault_led = (r_state == S_FAULT) || (r_state == S_LOCKOUT);
    assign bus.state     = r_state;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver
//   Directed vector table, hand-written corner sequences and a randomized run,
//   all shadowed cycle by cycle by a behavioural model of the driver rules.
module tb_motor_pwm_driver;
    localparam int P = 10;
    localparam int S = 20;
    localparam int W = 50;
    localparam int M = 2;
    localparam int ST_IDLE = 0, ST_RAMP = 1, ST_RUN = 2, ST_FAULT = 3, ST_LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    motor_pwm_driver_if bus();

    motor_pwm_driver #(
        .PWM_PERIOD(P), .RAMP_STEP(S), .RETRY_WAIT(W), .MAX_RETRIES(M)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: cycle index since reset gives the period phase,
    // ramp progress is "completed step intervals vs increments applied".
    int m_state, m_duty, m_dir, m_retry, m_wait, m_cyc, m_rampt, m_applied, m_hold, m_pwm;
    int m_fh0, m_fh1;

    task automatic model_reset();
        m_state = ST_IDLE; m_duty = 0; m_dir = 0; m_retry = 0; m_wait = 0;
        m_cyc = 0; m_rampt = 0; m_applied = 0; m_hold = 0; m_pwm = 0;
        m_fh0 = 0; m_fh1 = 0;
    endtask

    task automatic model_step();
        int fs, pc, tgt, d, earned;
        bit bnd;
        fs  = m_fh1;
        pc  = m_cyc % P;
        bnd = (pc == P - 1);
        d   = int'(bus.dir_cmd);
        tgt = (int'(bus.duty_cmd) > P) ? P : int'(bus.duty_cmd);
        m_pwm = 0;
        if (!bus.enable) begin
            m_state = ST_IDLE; m_duty = 0; m_retry = 0; m_wait = 0; m_hold = 0;
        end else begin
            case (m_state)
                ST_IDLE: if (fs == 0) begin
                    m_state = ST_RAMP; m_dir = d; m_duty = 0; m_rampt = 0; m_applied = 0;
                end
                ST_RAMP, ST_RUN: begin
                    if (fs != 0) begin
                        m_state = ST_FAULT; m_wait = 0; m_hold = 0;
                    end else if (m_hold == 0 && d != m_dir) begin
                        m_state = ST_RAMP; m_duty = 0; m_hold = P;
                    end else if (m_hold > 0) begin
                        m_hold--;
                        if (m_hold == 0) begin m_dir = d; m_rampt = 0; m_applied = 0; end
                    end else begin
                        m_pwm = (pc < m_duty) ? 1 : 0;
                        if (m_state == ST_RAMP) begin
                            earned = m_rampt / S;
                            if (bnd) begin
                                if (m_duty >= tgt) begin
                                    m_duty = tgt; m_state = ST_RUN;
                                end else if (earned > m_applied) begin
                                    m_duty++; m_applied++;
                                    if (m_duty == tgt) m_state = ST_RUN;
                                end
                            end
                            m_rampt++;
                        end else if (bnd) begin
                            m_duty = tgt;
                        end
                    end
                end
                ST_FAULT: begin
                    m_wait++;
                    if (m_wait >= W) begin
                        m_wait = 0;
                        if (m_retry >= M) m_state = ST_LOCK;
                        else if (fs == 0) begin
                            m_retry++; m_duty = 0; m_rampt = 0; m_applied = 0; m_state = ST_RAMP;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_fh1 = m_fh0;
        m_fh0 = int'(bus.fault);
        m_cyc++;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        logic exp_led;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_led = (m_state == ST_FAULT) || (m_state == ST_LOCK);
        total++;
        if (bus.state !== 3'(m_state) || bus.pwm_a !== m_pwm[0] || bus.pwm_b !== m_pwm[0] ||
            {bus.dir_b, bus.dir_a} !== 2'(m_dir) || bus.fault_led !== exp_led) begin
            bad++;
            $display("FAIL model cyc=%0d: got st=%0d pwm=%b%b dir=%b%b led=%b, want st=%0d pwm=%0d dir=%0d led=%b",
                     m_cyc, bus.state, bus.pwm_a, bus.pwm_b, bus.dir_b, bus.dir_a, bus.fault_led,
                     m_state, m_pwm, m_dir, exp_led);
        end
    endtask

    task automatic wait_state(input int st, input int max_cyc, input string name);
        int k;
        k = 0;
        while (bus.state !== 3'(st) && k < max_cyc) begin
            cycle();
            k++;
        end
        check(name, 16'(bus.state), 16'(st));
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  dir;
        logic [15:0] duty;
        logic        flt;
        int          n;
        logic [2:0]  st;
        logic [1:0]  xdir;
        logic        led;
        logic        pwm;
        bit          chk_pwm;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, k, fl;
        bus.enable = 1'b0; bus.dir_cmd = 2'b00; bus.duty_cmd = 16'd0; bus.fault = 1'b0;
        model_reset();

        //           en    dir    duty   flt   n    st    xdir   led   pwm   chk
        tbl[0]  = '{1'b0, 2'b00, 16'd4,  1'b0, 3,   3'd0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 2'b01, 16'd4,  1'b0, 1,   3'd1, 2'b01, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'b01, 16'd4,  1'b0, 100, 3'd2, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 16'd4,  1'b1, 5,   3'd3, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'b01, 16'd4,  1'b0, 20,  3'd3, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 2'b01, 16'd4,  1'b0, 40,  3'd1, 2'b01, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'b01, 16'd4,  1'b1, 5,   3'd3, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 2'b01, 16'd4,  1'b0, 60,  3'd1, 2'b01, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'b01, 16'd4,  1'b1, 5,   3'd3, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'b01, 16'd4,  1'b0, 60,  3'd4, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 2'b01, 16'd4,  1'b0, 1,   3'd0, 2'b01, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'b10, 16'd15, 1'b0, 1,   3'd1, 2'b10, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 2'b10, 16'd15, 1'b0, 260, 3'd2, 2'b10, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 2'b10, 16'd0,  1'b0, 15,  3'd2, 2'b10, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 2'b11, 16'd4,  1'b0, 3,   3'd1, 2'b10, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 2'b11, 16'd4,  1'b0, 15,  3'd1, 2'b11, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_state", 16'(bus.state), 16'd0);
        check("rst_pwm", 16'({bus.pwm_b, bus.pwm_a}), 16'd0);
        check("rst_dir", 16'({bus.dir_b, bus.dir_a}), 16'd0);
        check("rst_led", 16'(bus.fault_led), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus.enable = tbl[i].en; bus.dir_cmd = tbl[i].dir;
            bus.duty_cmd = tbl[i].duty; bus.fault = tbl[i].flt;
            repeat (tbl[i].n) cycle();
            check($sformatf("vec%0d_state", i), 16'(bus.state), 16'(tbl[i].st));
            check($sformatf("vec%0d_dir", i), 16'({bus.dir_b, bus.dir_a}), 16'(tbl[i].xdir));
            check($sformatf("vec%0d_led", i), 16'(bus.fault_led), 16'(tbl[i].led));
            if (tbl[i].chk_pwm) check($sformatf("vec%0d_pwm", i), 16'(bus.pwm_a), 16'(tbl[i].pwm));
        end

        // Soft start to duty 4: exactly 4 high cycles per 10-cycle period.
        wait_state(ST_RUN, 400, "softstart_run");
        hi = 0;
        repeat (10) begin
            cycle();
            hi += int'(bus.pwm_a);
        end
        check("softstart_high_cnt", 16'(hi), 16'd4);

        // Fault trip from full duty: gate low within 3 edges, 50-cycle wait, retry.
        bus.duty_cmd = 16'd10;
        repeat (25) cycle();
        check("full_duty_pwm", 16'(bus.pwm_a), 16'd1);
        bus.fault = 1'b1;
        repeat (3) cycle();
        check("fault_pwm_low", 16'({bus.pwm_b, bus.pwm_a}), 16'd0);
        check("fault_led_on", 16'(bus.fault_led), 16'd1);
        k = 0;
        while (bus.state !== 3'(ST_RAMP) && k < 100) begin
            if (k == 2) bus.fault = 1'b0;
            cycle();
            k++;
        end
        check("retry_wait_len", 16'(k), 16'd50);

        // Asynchronous reset in RUN: outputs drop between clock edges.
        wait_state(ST_RUN, 400, "pre_reset_run");
        repeat (12) cycle();
        check("pre_reset_pwm", 16'(bus.pwm_a), 16'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", 16'({bus.pwm_b, bus.pwm_a}), 16'd0);
        check("async_rst_state", 16'(bus.state), 16'd0);
        check("async_rst_dir", 16'({bus.dir_b, bus.dir_a}), 16'd0);
        check("async_rst_led", 16'(bus.fault_led), 16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_hold_state", 16'(bus.state), 16'd0);
        rst = 1'b0;
        cycle();
        check("post_rst_ramp", 16'(bus.state), 16'd1);

        // Randomized run against the model.
        fl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (bus.enable) begin
                if ($urandom_range(0, 299) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.enable = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) bus.dir_cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.duty_cmd = 16'($urandom_range(0, 15));
            if (fl == 0 && $urandom_range(0, 149) == 0)
                fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(1, 8));
            bus.fault = (fl > 0);
            if (fl > 0) fl--;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 Parameter PWM_PERIOD, default 1000, PWM period in clk cycles (100 kHz at 100 MHz).
REQ-002 Parameter RAMP_STEP, default 100000, clk cycles between soft-start duty increments.
REQ-003 Parameter RETRY_WAIT, default 200000000, clk cycles held in FAULT before a restart attempt.
REQ-004 Parameter MAX_RETRIES, default 3, restart attempts allowed before LOCKOUT.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 enable  input  1  drive request, level-sensitive.
REQ-008 dir_cmd  input  2  requested direction, bit0 for channel A and bit1 for channel B.
REQ-009 duty_cmd  input  16  target duty in clk counts per period.
REQ-010 fault  input  1  overcurrent flag, asynchronous to drive logic.
REQ-011 pwm_a, pwm_b  output  1 each  PWM gate drives for channels A and B.
REQ-012 dir_a, dir_b  output  1 each  latched direction outputs.
REQ-013 fault_led  output  1  high in FAULT and LOCKOUT.
REQ-014 state  output  3  encoded FSM state: IDLE=0, RAMP=1, RUN=2, FAULT=3, LOCKOUT=4.

Function
REQ-015 fault shall pass through a 2-flop synchronizer, and only the synchronized value fault_s shall be used.
REQ-016 Period counter pcnt shall count 0..PWM_PERIOD-1, wrap to 0, and run in all states.
REQ-017 Effective target shall be min(duty_cmd, PWM_PERIOD), and duty_cmd = PWM_PERIOD gives pwm constant high.
REQ-018 Applied duty duty_cur shall update only when pcnt = PWM_PERIOD-1, so no mid-period glitch occurs.
REQ-019 pwm_a and pwm_b shall both be registered (pcnt < duty_cur) in RAMP/RUN, and forced 0 in all other states.
REQ-020 IDLE -> RAMP when enable=1 and fault_s=0; on that transition, latch dir_a/dir_b from dir_cmd and set duty_cur=0.
REQ-021 RAMP: every RAMP_STEP cycles, duty_cur += 1, applied at the next period boundary.
REQ-022 RAMP -> RUN when duty_cur equals target; if target drops below duty_cur, clamp duty_cur to target at the next boundary and enter RUN.
REQ-023 RUN: duty_cur shall track target at each period boundary with no ramp.
REQ-024 RAMP/RUN: a dir_cmd change from latched value -> duty_cur=0 immediately, hold 0 for one full period, relatch dir, then re-enter RAMP.
REQ-025 RAMP/RUN: fault_s=1 -> FAULT next cycle, pwm outputs 0 on same edge, so fault pin to pwm low is at most 3 clk cycles.
REQ-026 FAULT: the wait counter shall count RETRY_WAIT cycles regardless of fault_s, then proceed as in REQ-027 or REQ-028.
REQ-027 If the wait completes, fault_s=0, and retry_cnt < MAX_RETRIES: retry_cnt += 1, duty_cur=0, go to RAMP.
REQ-028 If the wait completes and fault_s=1, restart the wait without incrementing retry_cnt.
REQ-029 FAULT with retry_cnt = MAX_RETRIES at wait completion -> LOCKOUT.
REQ-030 LOCKOUT shall be held until enable=0, and is then followed by IDLE.
REQ-031 enable=0 in any state -> IDLE next cycle, pwm 0, duty_cur=0, retry_cnt=0, wait counter cleared.
REQ-032 Fault has priority over a direction change when both are asserted in the same cycle, and enable=0 has priority over both.
REQ-033 Counters shall be wide enough for their parameter values, with no wrap-around in the wait or step counters.

Reset
REQ-034 While rst=1: state=IDLE, pwm_a=pwm_b=0, dir_a=dir_b=0, fault_led=0, all counters and synchronizer flops 0.
REQ-035 A reset asserted mid-RUN shall drive pwm low asynchronously, with no wait for a clk edge.
REQ-036 After rst deasserts with enable=1, the block shall pass through IDLE to RAMP on the first edge and ramp from 0.

Verification (PWM_PERIOD=10, RAMP_STEP=20, RETRY_WAIT=50, MAX_RETRIES=2)
REQ-037 Soft-start: enable=1, duty_cmd=4 -> duty_cur steps 1,2,3,4 at period boundaries, then state=RUN with pwm high 4 of every 10 cycles.
REQ-038 Fault trip: in RUN, pulse fault for 5 cycles -> pwm low within 3 cycles, fault_led=1, and after 50 cycles RAMP with retry_cnt=1.
REQ-039 Lockout: a persistent fault re-asserted after each restart -> third trip reaches LOCKOUT; enable=0 -> IDLE and retry_cnt=0.
REQ-040 Direction change: in RUN, toggle dir_cmd bit0 -> pwm 0 for one full period, dir_a flips, and RAMP restarts from 0.
REQ-041 Clamp: duty_cmd=15 -> ramp stops at 10 with pwm constant high, and duty_cmd=0 in RUN -> pwm low from the next period.
REQ-042 Async reset: assert rst between clk edges in RUN -> pwm low immediately, all outputs at reset values.
